// File: rtl/clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime on a single-cycle bus slave.
// Optional CLINT_MTIME_LATCH_EN: a read of mtime[31:0] latches mtime[63:32] for a tear-free high read.
module clint #(
  parameter int unsigned RTC_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime
);

  localparam logic [15:0] PRESC_MAX = 16'(RTC_DIV - 1);
  localparam logic [15:0] A_MSIP    = 16'h0000;
  localparam logic [15:0] A_CMP_LO  = 16'h4000;
  localparam logic [15:0] A_CMP_HI  = 16'h4004;
  localparam logic [15:0] A_MT_LO   = 16'hBFF8;
  localparam logic [15:0] A_MT_HI   = 16'hBFFC;

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] a;
  logic        wr, rd, tick;
  logic        unused_addr_hi;
`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] shadow_q, shadow_d;
`endif

  assign unused_addr_hi = ^mem_addr[31:16];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  always_comb begin
    a          = mem_addr[15:0];
    wr         = mem_valid && (mem_wstrb != '0);
    rd         = mem_valid && (mem_wstrb == '0);
    tick       = (presc_q == PRESC_MAX);
    presc_d    = tick ? '0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
`ifdef CLINT_MTIME_LATCH_EN
    shadow_d   = shadow_q;
`endif
    // A bus write to either mtime half overrides the tick increment for that cycle.
    if (wr) begin
      case (a)
        A_MSIP:   if (mem_wstrb[0]) msip_d = mem_wdata[0];
        A_CMP_LO: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
        A_CMP_HI: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
        A_MT_LO:  mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], mem_wdata, mem_wstrb)};
        A_MT_HI: begin
          mtime_d = {merge(mtime_q[63:32], mem_wdata, mem_wstrb), mtime_q[31:0]};
`ifdef CLINT_MTIME_LATCH_EN
          shadow_d = mtime_d[63:32];
`endif
        end
        default: ;
      endcase
    end
    rdata_d = '0;
    if (rd) begin
      case (a)
        A_MSIP:   rdata_d = {31'd0, msip_q};
        A_CMP_LO: rdata_d = mtimecmp_q[31:0];
        A_CMP_HI: rdata_d = mtimecmp_q[63:32];
        A_MT_LO: begin
          rdata_d = mtime_q[31:0];
`ifdef CLINT_MTIME_LATCH_EN
          shadow_d = mtime_q[63:32];
`endif
        end
`ifdef CLINT_MTIME_LATCH_EN
        A_MT_HI:  rdata_d = shadow_q;
`else
        A_MT_HI:  rdata_d = mtime_q[63:32];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
`ifdef CLINT_MTIME_LATCH_EN
      shadow_q   <= '0;
`endif
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
      ready_q    <= mem_valid;
      rdata_q    <= rdata_d;
`ifdef CLINT_MTIME_LATCH_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign mtip      = mtip_q;
  assign msip      = msip_q;
  assign mtime     = mtime_q;

endmodule
